// File: rtl/user_wb_exmem_pkg.sv
// Shared FSM encoding, CSR map and request record for the external-memory emulator.
package user_wb_exmem_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [3:0]  CSR_REGION = 4'hF;
    localparam logic [15:0] CSR_DELAY  = 16'h0000;
    localparam logic [15:0] CSR_RD_CNT = 16'h0004;
    localparam logic [15:0] CSR_WR_CNT = 16'h0008;
    localparam logic [15:0] CSR_CTRL   = 16'h000C;

    // Memory access held across the wait window; the word index lives beside it.
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } mem_req_t;

endpackage

// File: rtl/user_wb_exmem_bank.sv
// Synchronous single-port word RAM, read-first, registered output, byte write enables.
module exmem_bank #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/user_wb_exmem.sv
// Wishbone slave emulating slow external memory: programmable wait states,
// access counters in a CSR window at offset 0xF_0000, error on unmapped offsets.
module user_wb_exmem
    import user_wb_exmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          DELAYS     = 10,
    parameter int          DLY_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);

    state_t                state;
    logic [DLY_W-1:0]      wcnt;
    logic [DLY_W-1:0]      delay_q;
    logic [31:0]           rd_cnt;
    logic [31:0]           wr_cnt;
    logic                  ack_q;
    logic                  err_q;
    logic                  rd_mem_q;
    logic [31:0]           rdata_q;
    mem_req_t              req_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           bank_dout;

    logic [19:0] off;
    logic        hit, strobe, req, is_csr, csr_ok, mem_oob, unmapped;
    logic        commit, csr_wr, clr;
    logic [31:0] csr_rdata;
    mem_req_t              cur;
    logic [DEPTH_LOG2-1:0] cur_idx;

    assign off      = wbs_adr_i[19:0];
    assign hit      = wbs_adr_i[31:20] == BASE_ADDR[31:20];
    assign strobe   = wbs_cyc_i & wbs_stb_i;
    assign req      = strobe & hit;
    assign is_csr   = off[19:16] == CSR_REGION;
    assign csr_ok   = off[15:0] inside {CSR_DELAY, CSR_RD_CNT, CSR_WR_CNT, CSR_CTRL};
    // Any address bit above the implemented depth inside the 64 KiB window is unmapped.
    assign mem_oob  = |(off[15:0] >> (DEPTH_LOG2 + 2));
    assign unmapped = is_csr ? !csr_ok : mem_oob;

    always_comb begin
        csr_rdata = '0;
        case (off[15:0])
            CSR_DELAY:  csr_rdata = 32'(delay_q);
            CSR_RD_CNT: csr_rdata = rd_cnt;
            CSR_WR_CNT: csr_rdata = wr_cnt;
            default:    csr_rdata = '0;
        endcase
    end

    // Zero-wait accesses commit straight from the bus; delayed ones from the latched copy.
    always_comb begin
        cur     = req_q;
        cur_idx = idx_q;
        if (state == ST_IDLE) begin
            cur     = '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
            cur_idx = off[DEPTH_LOG2+1:2];
        end
    end

    assign commit = (state == ST_IDLE && req && !unmapped && !is_csr && delay_q == '0) ||
                    (state == ST_WAIT && strobe && wcnt == DLY_W'(1));
    assign csr_wr = state == ST_IDLE && req && is_csr && csr_ok && wbs_we_i;
    assign clr    = csr_wr && off[15:0] == CSR_CTRL && wbs_dat_i[0];

    exmem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
        .clk  (wb_clk_i),
        .en   (commit),
        .we   ((commit && cur.we) ? cur.sel : 4'b0000),
        .addr (cur_idx),
        .din  (cur.dat),
        .dout (bank_dout)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            delay_q  <= DLY_W'(DELAYS);
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_mem_q <= 1'b0;
            rdata_q  <= '0;
            req_q    <= '0;
            idx_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        req_q <= cur;
                        idx_q <= cur_idx;
                        if (unmapped) begin
                            state <= ST_RESP;
                            err_q <= 1'b1;
                        end else if (is_csr) begin
                            state    <= ST_RESP;
                            ack_q    <= 1'b1;
                            rd_mem_q <= 1'b0;
                            rdata_q  <= csr_rdata;
                            if (csr_wr && off[15:0] == CSR_DELAY) delay_q <= wbs_dat_i[DLY_W-1:0];
                        end else if (delay_q == '0) begin
                            state    <= ST_RESP;
                            ack_q    <= 1'b1;
                            rd_mem_q <= !wbs_we_i;
                            rdata_q  <= '0;
                        end else begin
                            state <= ST_WAIT;
                            wcnt  <= delay_q;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!strobe) begin
                        state <= ST_IDLE;
                    end else if (wcnt == DLY_W'(1)) begin
                        state    <= ST_RESP;
                        ack_q    <= 1'b1;
                        rd_mem_q <= !req_q.we;
                        rdata_q  <= '0;
                    end else begin
                        wcnt <= wcnt - DLY_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (clr) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else if (commit) begin
                if (cur.we) wr_cnt <= wr_cnt + 32'd1;
                else        rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign busy_o    = state == ST_WAIT;
    assign wbs_dat_o = !ack_q ? 32'd0 : (rd_mem_q ? bank_dout : rdata_q);

endmodule

// File: tb/tb_user_wb_exmem.sv
// Directed bench for user_wb_exmem against a word-array / counter model of the emulator.
module tb_user_wb_exmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack, err, busy;
    logic [31:0] dat_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // model state
    logic [31:0] mdl_mem [int];
    int          mdl_delay = 10;
    logic [31:0] mdl_rd = 0, mdl_wr = 0;

    localparam logic [31:0] BASE = 32'h3800_0000;
    localparam logic [31:0] CSR  = 32'h380F_0000;

    always #5 clk = ~clk;

    user_wb_exmem dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_err_o(err),
        .wbs_dat_o(dat_o),
        .busy_o   (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bus transfer; expectations come from the model, then the model is updated.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat_o);
        bit          csr, mapped, known, got_ack, got_err, busy_bad;
        int          off16, idx, lat, n;
        logic [31:0] exp_rd;
        csr    = (a & 32'h000F_0000) == 32'h000F_0000;
        off16  = int'(a & 32'hFFFF);
        mapped = csr ? (off16 == 0 || off16 == 4 || off16 == 8 || off16 == 12) : (off16 < 32'h4000);
        idx    = int'((a & 32'h3FFF) / 4);
        lat    = (csr || !mapped) ? 1 : mdl_delay + 1;
        known  = 1'b1;
        exp_rd = 0;
        if (csr) begin
            case (off16)
                0:       exp_rd = 32'(mdl_delay);
                4:       exp_rd = mdl_rd;
                8:       exp_rd = mdl_wr;
                default: exp_rd = 0;
            endcase
        end else if (mdl_mem.exists(idx)) exp_rd = mdl_mem[idx];
        else known = 1'b0;

        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
        n = 0; got_ack = 0; got_err = 0; busy_bad = 0;
        while (!(got_ack || got_err) && n < 400) begin
            @(posedge clk); #1;
            n++;
            got_ack = ack; got_err = err;
            if (!(got_ack || got_err) && n < lat && busy !== 1'b1) busy_bad = 1;
        end
        check("latency", n, lat);
        check("busy_wait", busy_bad, 0);
        check("err", err, !mapped);
        check("ack", ack, mapped);
        if (!w && mapped && known) check("rdata", dat_o, exp_rd);
        rd = dat_o;
        lat_o = n;
        cyc = 0; stb = 0; we = 0;

        if (mapped && got_ack) begin
            if (csr && w) begin
                if (off16 == 0) mdl_delay = int'(d & 32'hFF);
                if (off16 == 12 && d[0]) begin mdl_rd = 0; mdl_wr = 0; end
            end else if (!csr) begin
                if (w) begin
                    if (mdl_mem.exists(idx) || s == 4'hF) begin
                        logic [31:0] word;
                        word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                        mdl_mem[idx] = word;
                    end
                    mdl_wr = mdl_wr + 1;
                end else mdl_rd = mdl_rd + 1;
            end
        end
        @(posedge clk); #1;
        check("resp_one_cycle", {30'd0, ack, err}, 0);
        check("dat_idle_zero", dat_o, 0);
    endtask

    logic [31:0] r;
    int          lat;
    bit          abort_bad;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {28'd0, ack, err, busy, |dat_o}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_outputs", {28'd0, ack, err, busy, |dat_o}, 0);

        xfer(0, CSR + 32'h0, 4'hF, 0, r, lat);
        check("delay_reset_val", r, 32'd10);
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);
        check("wrcnt_reset_val", r, 32'd0);

        // default wait states
        xfer(1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, r, lat);
        check("t1_wr_lat", lat, 11);
        xfer(0, BASE + 32'h10, 4'hF, 0, r, lat);
        check("t1_rd_lat", lat, 11);
        check("t1_rd_data", r, 32'hDEAD_BEEF);

        // zero wait states, counters from a clean start
        xfer(1, CSR + 32'hC, 4'hF, 32'h1, r, lat);
        xfer(1, CSR + 32'h0, 4'hF, 32'h0, r, lat);
        xfer(0, BASE + 32'h0, 4'hF, 0, r, lat);
        check("t2_lat0", lat, 1);
        xfer(0, BASE + 32'h4, 4'hF, 0, r, lat);
        check("t2_lat1", lat, 1);
        xfer(0, CSR + 32'h4, 4'hF, 0, r, lat);
        check("t2_rdcnt", r, 32'd2);

        // byte lanes
        xfer(1, BASE + 32'h8, 4'hF, 32'h1122_3344, r, lat);
        xfer(1, BASE + 32'h8, 4'b0010, 32'h0000_AB00, r, lat);
        xfer(0, BASE + 32'h8, 4'hF, 0, r, lat);
        check("t3_partial", r, 32'h1122_AB44);
        xfer(1, BASE + 32'h8, 4'b0000, 32'hFFFF_FFFF, r, lat);
        xfer(0, BASE + 32'h8, 4'hF, 0, r, lat);
        check("t3_sel0", r, 32'h1122_AB44);

        // unmapped offsets
        xfer(1, BASE + 32'h0, 4'hF, 32'hA5A5_A5A5, r, lat);
        xfer(0, CSR + 32'h10, 4'hF, 0, r, lat);
        xfer(1, CSR + 32'h10, 4'hF, 32'h1, r, lat);
        xfer(1, BASE + 32'h4000, 4'hF, 32'h0BAD_0BAD, r, lat);
        xfer(0, BASE + 32'h4000, 4'hF, 0, r, lat);
        xfer(0, BASE + 32'h0, 4'hF, 0, r, lat);
        check("t4_alias_untouched", r, 32'hA5A5_A5A5);
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);
        xfer(0, CSR + 32'h4, 4'hF, 0, r, lat);

        // abort during wait
        xfer(1, CSR + 32'h0, 4'hF, 32'd5, r, lat);
        xfer(1, BASE + 32'h20, 4'hF, 32'h1234_5678, r, lat);
        check("t5_lat", lat, 6);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h20; sel = 4'hF; dat = 32'hCAFE_F00D;
        abort_bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack || err) abort_bad = 1;
        end
        cyc = 0; stb = 0; we = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack || err) abort_bad = 1;
        end
        check("t5_no_resp", abort_bad, 0);
        check("t5_idle_after", busy, 0);
        xfer(0, BASE + 32'h20, 4'hF, 0, r, lat);
        check("t5_word_kept", r, 32'h1234_5678);
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);

        // write counter wrap
        xfer(1, CSR + 32'h0, 4'hF, 32'd0, r, lat);
        force dut.wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt;
        mdl_wr = 32'hFFFF_FFFF;
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);
        xfer(1, BASE + 32'h30, 4'hF, 32'h0000_0030, r, lat);
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);
        check("t6_wrap", r, 32'd0);

        // clear right behind a memory ack
        xfer(1, BASE + 32'h34, 4'hF, 32'h0000_0034, r, lat);
        xfer(0, BASE + 32'h34, 4'hF, 0, r, lat);
        xfer(1, CSR + 32'hC, 4'hF, 32'h1, r, lat);
        xfer(0, CSR + 32'hC, 4'hF, 0, r, lat);
        check("t7_ctrl_reads0", r, 32'd0);
        xfer(0, CSR + 32'h4, 4'hF, 0, r, lat);
        check("t7_rdcnt0", r, 32'd0);
        xfer(0, CSR + 32'h8, 4'hF, 0, r, lat);
        check("t7_wrcnt0", r, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
